// File: rtl/pipe_pkg.sv
// Shared widths and control-bundle encoding for the decode/execute pipeline.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned CTRL_W_DEF  = 7;
  localparam int unsigned NUM_SRC_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 16;

  // All-zero control: no register write, no memory write.
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

  localparam int unsigned CTRL_WRITEREG  = 0;
  localparam int unsigned CTRL_MEMTOREG  = 1;
  localparam int unsigned CTRL_MEMWRITE  = 2;
  localparam int unsigned CTRL_ALUCTL_LO = 3;
  localparam int unsigned CTRL_ALUCTL_HI = 4;
  localparam int unsigned CTRL_ALUSRC    = 5;
  localparam int unsigned CTRL_REGDST    = 6;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with a 0..3 increment per cycle.
module pipe_sat_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SUM_W-1:0] sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + SUM_W'(inc_i);
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/idex_skid_stage.sv
// Decode-to-execute stage register with a 2-entry skid buffer and flush.
// Optional stall/flush perf counters when IDEX_SKID_PERF_EN is defined.
module idex_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned CTRL_W  = CTRL_W_DEF,
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
`ifdef IDEX_SKID_PERF_EN
  , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [NUM_SRC*ADDR_W-1:0] in_srcidx,
  input  logic [ADDR_W-1:0]         in_dst,
  input  logic [DATA_W-1:0]         in_imm,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_SRC*DATA_W-1:0] out_src,
  output logic [NUM_SRC*ADDR_W-1:0] out_srcidx,
  output logic [ADDR_W-1:0]         out_dst,
  output logic [DATA_W-1:0]         out_imm
`ifdef IDEX_SKID_PERF_EN
  , output logic [CNT_W-1:0]        stall_cnt
  , output logic [CNT_W-1:0]        flush_cnt
`endif
);

  localparam int unsigned SRC_W = NUM_SRC * DATA_W;
  localparam int unsigned IDX_W = NUM_SRC * ADDR_W;
  localparam int unsigned DAT_W = SRC_W + IDX_W + ADDR_W + DATA_W;
  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(CTRL_BUBBLE);

  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DAT_W-1:0]  m_data_q, m_data_d, s_data_q, s_data_d;
  logic [DAT_W-1:0]  in_data;
  logic              accept, pop;

  assign in_data  = {in_src, in_srcidx, in_dst, in_imm};
  assign in_ready = RST & ~s_valid_q;
  assign accept   = in_valid & in_ready;
  assign pop      = m_valid_q & out_ready;

  // Next-state for main (M) and skid (S) entries; flush wins over movement.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_ctrl_d  = m_ctrl_q;
    s_ctrl_d  = s_ctrl_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (CLR) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = BUBBLE;
      s_ctrl_d  = BUBBLE;
    end else if (pop && s_valid_q) begin
      m_valid_d = 1'b1;
      m_ctrl_d  = s_ctrl_q;
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
    end else if (pop || !m_valid_q) begin
      m_valid_d = accept;
      if (accept) begin
        m_ctrl_d = in_ctrl;
        m_data_d = in_data;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      s_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      s_ctrl_q  <= s_ctrl_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : BUBBLE;
  assign {out_src, out_srcidx, out_dst, out_imm} = m_data_q;

`ifdef IDEX_SKID_PERF_EN
  logic [1:0] stall_inc;
  logic [1:0] flush_inc;

  // Beats lost to a flush: occupied entries plus a same-cycle accept.
  always_comb begin
    stall_inc = {1'b0, m_valid_q & ~out_ready};
    flush_inc = 2'b00;
    if (CLR) begin
      flush_inc = 2'({1'b0, m_valid_q}) + 2'({1'b0, s_valid_q}) + 2'({1'b0, accept});
    end
  end

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_idex_skid_stage.sv
// Bench for idex_skid_stage: vector table plus a queue-based reference model.
module tb_idex_skid_stage;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 7;
  localparam int unsigned NS = 2;
`ifdef IDEX_SKID_PERF_EN
  localparam int unsigned TCW = 4;
  localparam int unsigned CNT_MAX = (1 << TCW) - 1;
`endif

  logic              CLK, RST, CLR;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]     in_ctrl, out_ctrl;
  logic [NS*DW-1:0]  in_src, out_src;
  logic [NS*AW-1:0]  in_srcidx, out_srcidx;
  logic [AW-1:0]     in_dst, out_dst;
  logic [DW-1:0]     in_imm, out_imm;
`ifdef IDEX_SKID_PERF_EN
  logic [TCW-1:0]    stall_cnt, flush_cnt;
`endif

  idex_skid_stage #(
    .DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .NUM_SRC(NS)
`ifdef IDEX_SKID_PERF_EN
    , .CNT_W(TCW)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_src(in_src),
    .in_srcidx(in_srcidx), .in_dst(in_dst), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_src(out_src),
    .out_srcidx(out_srcidx), .out_dst(out_dst), .out_imm(out_imm)
`ifdef IDEX_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [9:0]  sidx;
    logic [4:0]  dst;
    logic [31:0] imm;
  } beat_t;

  typedef struct {
    logic  rst, clr, iv, ordy;
    beat_t b;
    logic  eir, eov;
  } vec_t;

  beat_t       q[$];
  int          checks, errors;
  int unsigned stall_m, flush_m;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mkb(input logic [6:0] c, input logic [31:0] s0, input logic [31:0] s1,
                                input logic [4:0] d, input logic [31:0] imm);
    beat_t b;
    b.ctrl = c; b.s0 = s0; b.s1 = s1; b.dst = d; b.imm = imm;
    b.sidx = {5'(d + 5'd1), 5'(d + 5'd2)};
    return b;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic clr, input logic iv, input logic ordy,
                               input beat_t b, input logic eir, input logic eov);
    vec_t v;
    v.rst = rst; v.clr = clr; v.iv = iv; v.ordy = ordy; v.b = b; v.eir = eir; v.eov = eov;
    return v;
  endfunction

`ifdef IDEX_SKID_PERF_EN
  function automatic int unsigned sat(input int unsigned x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction
`endif

  // Drive one cycle, advance the model at the edge, compare just after it.
  task automatic step(input vec_t v, input bit use_exp, input string tag);
    int   n;
    logic acc, pop;
    RST = v.rst; CLR = v.clr; in_valid = v.iv; out_ready = v.ordy;
    in_ctrl = v.b.ctrl; in_src = {v.b.s1, v.b.s0}; in_srcidx = v.b.sidx;
    in_dst = v.b.dst; in_imm = v.b.imm;
    n   = q.size();
    acc = v.rst && v.iv && (n < 2);
    pop = (n > 0) && v.ordy;
    @(posedge CLK);
`ifdef IDEX_SKID_PERF_EN
    if (!v.rst) begin
      stall_m = 0; flush_m = 0;
    end else begin
      if (n > 0 && !v.ordy) stall_m = sat(stall_m + 1);
      if (v.clr) flush_m = sat(flush_m + n + (acc ? 1 : 0));
    end
`endif
    if (!v.rst || v.clr) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(v.b);
    end
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(v.rst && q.size() < 2));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    if (use_exp) begin
      check({tag, ".tbl_in_ready"}, 64'(in_ready), 64'(v.eir));
      check({tag, ".tbl_out_valid"}, 64'(out_valid), 64'(v.eov));
    end
    if (q.size() > 0) begin
      check({tag, ".ctrl"}, 64'(out_ctrl), 64'(q[0].ctrl));
      check({tag, ".src"}, 64'(out_src), {q[0].s1, q[0].s0});
      check({tag, ".srcidx"}, 64'(out_srcidx), 64'(q[0].sidx));
      check({tag, ".dst"}, 64'(out_dst), 64'(q[0].dst));
      check({tag, ".imm"}, 64'(out_imm), 64'(q[0].imm));
    end else begin
      check({tag, ".bubble_ctrl"}, 64'(out_ctrl), 64'd0);
    end
`ifdef IDEX_SKID_PERF_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(stall_m));
    check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(flush_m));
`endif
  endtask

  vec_t  vecs[22];
  beat_t nb, p1, p2, p3, ba, bb, bc, bd, be, bf, bg;

  initial begin
    checks = 0; errors = 0; stall_m = 0; flush_m = 0;
    RST = 1'b0; CLR = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_src = '0; in_srcidx = '0; in_dst = '0; in_imm = '0;

    nb = mkb(7'h00, 32'h0, 32'h0, 5'd0, 32'h0);
    p1 = mkb(7'((1 << CTRL_WRITEREG) | (1 << CTRL_ALUSRC) | (1 << CTRL_REGDST)),
             32'h11, 32'h22, 5'd3, 32'hFFFF_FFFC);
    p2 = mkb(7'h23, 32'h33, 32'h44, 5'd7, 32'h5);
    p3 = mkb(7'h45, 32'h55, 32'h66, 5'd9, 32'hFFFF_0000);
    ba = mkb(7'h01, 32'hA0, 32'hA1, 5'd1, 32'h10);
    bb = mkb(7'h04, 32'hB0, 32'hB1, 5'd2, 32'h20);
    bc = mkb(7'h19, 32'hC0, 32'hC1, 5'd4, 32'h30);
    bd = mkb(7'h7F, 32'hD0, 32'hD1, 5'd5, 32'h40);
    be = mkb(7'h21, 32'hE0, 32'hE1, 5'd6, 32'h50);
    bf = mkb(7'h03, 32'hF0, 32'hF1, 5'd8, 32'h60);
    bg = mkb(7'h41, 32'h90, 32'h91, 5'd10, 32'h70);

    //            rst  clr  iv   ordy beat ir   ov
    vecs[0]  = mkv(0, 0, 1, 0, p1, 0, 0);
    vecs[1]  = mkv(0, 0, 1, 0, p1, 0, 0);
    vecs[2]  = mkv(1, 0, 0, 1, nb, 1, 0);
    vecs[3]  = mkv(1, 0, 1, 1, p1, 1, 1);
    vecs[4]  = mkv(1, 0, 1, 1, p2, 1, 1);
    vecs[5]  = mkv(1, 0, 1, 1, p3, 1, 1);
    vecs[6]  = mkv(1, 0, 0, 1, nb, 1, 0);
    vecs[7]  = mkv(1, 0, 1, 0, ba, 1, 1);
    vecs[8]  = mkv(1, 0, 1, 0, bb, 0, 1);
    vecs[9]  = mkv(1, 0, 1, 0, bc, 0, 1);
    vecs[10] = mkv(1, 0, 1, 1, bc, 1, 1);
    vecs[11] = mkv(1, 0, 1, 1, bc, 1, 1);
    vecs[12] = mkv(1, 0, 0, 1, nb, 1, 0);
    vecs[13] = mkv(1, 0, 1, 0, ba, 1, 1);
    vecs[14] = mkv(1, 0, 1, 0, bb, 0, 1);
    vecs[15] = mkv(1, 1, 1, 0, bd, 1, 0);
    vecs[16] = mkv(1, 0, 0, 1, nb, 1, 0);
    vecs[17] = mkv(1, 1, 1, 1, be, 1, 0);
    vecs[18] = mkv(1, 0, 0, 1, nb, 1, 0);
    vecs[19] = mkv(1, 0, 1, 0, bf, 1, 1);
    vecs[20] = mkv(1, 1, 1, 1, bg, 1, 0);
    vecs[21] = mkv(1, 0, 0, 1, nb, 1, 0);

    for (int i = 0; i < 22; i++) step(vecs[i], 1'b1, $sformatf("v%0d", i));

    // Long stall: counter must pin at its maximum.
    step(mkv(1, 1, 0, 1, nb, 1, 0), 1'b0, "sat_clr");
    step(mkv(1, 0, 1, 0, ba, 1, 1), 1'b0, "sat_load");
    for (int i = 0; i < 20; i++) step(mkv(1, 0, 0, 0, nb, 1, 1), 1'b0, $sformatf("sat%0d", i));
`ifdef IDEX_SKID_PERF_EN
    check("stall_saturated", 64'(stall_cnt), 64'(CNT_MAX));
`endif

    // Random streaming with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      vec_t v;
      v = mkv(1, ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              mkb(7'($urandom), $urandom, $urandom, 5'($urandom), $urandom), 0, 0);
      step(v, 1'b0, $sformatf("rnd%0d", i));
    end

    // Drain and re-check reset behaviour mid-stream.
    step(mkv(1, 0, 1, 0, bc, 1, 1), 1'b0, "pre_rst");
    step(mkv(0, 0, 1, 1, bd, 0, 0), 1'b1, "mid_rst");
    step(mkv(1, 0, 0, 1, nb, 1, 0), 1'b1, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
